br_resolve: RTL

- Branch resolution stage directly upstream of the branch stack.
- Collects up to N completed branch results per cycle from the branch FUs and detects mispredicts.
- Buffers the results and issues one BR_TASK per cycle (NOTHING/CLEAR/SQUASH), with the one-hot rem_b_id and, on SQUASH, a fetch redirect PC.
- Orders resolutions so the oldest mispredict is squashed first, and keeps buffered masks coherent with its own broadcasts.

---
 rtl/br_resolve.sv | 127 ++++++++++++
 1 files changed

// File: rtl/br_resolve.sv
// br_resolve: branch resolution stage; buffers FU branch results and issues one CLEAR/SQUASH per cycle, oldest mispredict first
// Ports: clock/reset (sync, active-high); br_* are N result lanes (one-hot b_id, dependency b_mask, pc, actual/predicted direction and target);
// br_task/rem_b_id/redirect_valid/redirect_pc are the registered broadcast; pending_cnt is the registered buffer occupancy.
module br_resolve #(
  parameter int DEPTH = 4,
  parameter int N = 2,
  parameter int XLEN = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  br_valid,
  input  logic [N-1:0][DEPTH-1:0]       br_b_id,
  input  logic [N-1:0][DEPTH-1:0]       br_b_mask,
  input  logic [N-1:0][XLEN-1:0]        br_pc,
  input  logic [N-1:0]                  br_taken,
  input  logic [N-1:0][XLEN-1:0]        br_target,
  input  logic [N-1:0]                  br_pred_taken,
  input  logic [N-1:0][XLEN-1:0]        br_pred_target,
  output logic [1:0]                    br_task,
  output logic [DEPTH-1:0]              rem_b_id,
  output logic                          redirect_valid,
  output logic [XLEN-1:0]               redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]    pending_cnt
);
  localparam int C = DEPTH + N;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {NOTHING = 2'd0, CLEAR = 2'd1, SQUASH = 2'd2} br_task_e;
  typedef struct packed {
    logic             v;
    logic             mp;
    logic [DEPTH-1:0] id;
    logic [DEPTH-1:0] mask;
    logic [XLEN-1:0]  pc;
  } ent_t;
  ent_t [DEPTH-1:0] slot_q, slot_d;
  ent_t [C-1:0]     cand;
  logic [C-1:0]     in_set, elig, sel_oh, keep;
  logic             any_mp, found, placed;
  logic [DEPTH-1:0] sel_id, used, rem_q, rem_d;
  logic [XLEN-1:0]  sel_pc, rpc_q, rpc_d;
  logic             rv_q, rv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  br_task_e         task_q, task_d;
  assign br_task        = task_q;
  assign rem_b_id       = rem_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign pending_cnt    = cnt_q;
  // Buffered slots first, then incoming lanes: index order doubles as the tie-break order.
  // Incoming lanes are filtered against the broadcast currently on the outputs, which the FUs also saw.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) cand[i] = slot_q[i];
    for (int l = 0; l < N; l++) begin
      cand[DEPTH+l].v    = br_valid[l] && !(task_q == SQUASH && |(br_b_mask[l] & rem_q));
      cand[DEPTH+l].id   = br_b_id[l];
      cand[DEPTH+l].mask = task_q == CLEAR ? br_b_mask[l] & ~rem_q : br_b_mask[l];
      cand[DEPTH+l].mp   = (br_taken[l] != br_pred_taken[l]) || (br_taken[l] && br_target[l] != br_pred_target[l]);
      cand[DEPTH+l].pc   = br_taken[l] ? br_target[l] : br_pc[l] + XLEN'(4);
    end
  end
  always_comb begin
    any_mp = 1'b0;
    for (int i = 0; i < C; i++) any_mp = any_mp | (cand[i].v & cand[i].mp);
    // With any mispredict present only mispredicts compete, so the oldest mispredict wins.
    for (int i = 0; i < C; i++) in_set[i] = cand[i].v && (!any_mp || cand[i].mp);
    found  = 1'b0;
    sel_oh = '0;
    sel_id = '0;
    sel_pc = '0;
    for (int i = 0; i < C; i++) begin
      elig[i] = in_set[i];
      for (int j = 0; j < C; j++) if (in_set[j] && |(cand[i].mask & cand[j].id)) elig[i] = 1'b0;
      sel_oh[i] = elig[i] && !found;
      found = found | elig[i];
      if (sel_oh[i]) begin
        sel_id = cand[i].id;
        sel_pc = cand[i].pc;
      end
    end
    task_d = !found ? NOTHING : (any_mp ? SQUASH : CLEAR);
    rem_d  = sel_id;
    rv_d   = task_d == SQUASH;
    rpc_d  = rv_d ? sel_pc : '0;
    for (int i = 0; i < C; i++) keep[i] = cand[i].v && !sel_oh[i] && !(task_d == SQUASH && |(cand[i].mask & sel_id));
    // Surviving buffered entries stay put; surviving lanes fill the lowest free slots in lane order.
    slot_d = '0;
    used   = '0;
    placed = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (keep[s]) begin
        slot_d[s] = cand[s];
        used[s]   = 1'b1;
      end
    end
    for (int l = 0; l < N; l++) begin
      placed = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        if (keep[DEPTH+l] && !placed && !used[s]) begin
          slot_d[s] = cand[DEPTH+l];
          used[s]   = 1'b1;
          placed    = 1'b1;
        end
      end
    end
    // Stored masks follow our own CLEAR so buffered entries never need re-filtering.
    for (int s = 0; s < DEPTH; s++) if (task_d == CLEAR) slot_d[s].mask = slot_d[s].mask & ~sel_id;
    cnt_d = '0;
    for (int s = 0; s < DEPTH; s++) cnt_d = cnt_d + CW'(used[s]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
      task_q <= NOTHING;
      rem_q  <= '0;
      rv_q   <= 1'b0;
      rpc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      task_q <= task_d;
      rem_q  <= rem_d;
      rv_q   <= rv_d;
      rpc_q  <= rpc_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
